// File: rtl/fec_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// fec_pkg : shared definitions for the rate-1/2 K=4 convolutional code (rev 1.0)
// ------------------------------------------------------------------------
package fec_pkg;

  localparam int K          = 4;
  localparam int NUM_STATES = 8;

  localparam logic [3:0] G_UPPER = 4'b1111;
  localparam logic [3:0] G_LOWER = 4'b1011;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACS    = 3'd1,
    ST_SELECT = 3'd2,
    ST_TRACE  = 3'd3,
    ST_FINISH = 3'd4
  } vit_state_t;

  // Coded pair {upper, lower} emitted when bit b enters an encoder in state s.
  function automatic logic [1:0] expected_pair(input logic [2:0] state, input logic b);
    logic [3:0] taps;
    taps = {b, state};
    return {^(taps & G_UPPER), ^(taps & G_LOWER)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fec_viterbi_decoder_acs.sv
`default_nettype none
// ------------------------------------------------------------------------
// viterbi_acs : combinational add-compare-select across all 8 trellis states (rev 1.0)
// ------------------------------------------------------------------------
module viterbi_acs
  import fec_pkg::*;
#(
  parameter int METRIC_WIDTH = 8
) (
  input  logic [NUM_STATES-1:0][METRIC_WIDTH-1:0] metric_in,
  input  logic [1:0]                              rx_pair,
  output logic [NUM_STATES-1:0][METRIC_WIDTH-1:0] metric_out,
  output logic [NUM_STATES-1:0]                   decision
);

  genvar n;
  generate
    for (n = 0; n < NUM_STATES; n++) begin : g_state
      // Next state n = {b, s2, s1}: predecessors share s2,s1 = n[1:0], input bit = n[2].
      localparam logic [2:0] PRED0 = 3'((n % 4) * 2);
      localparam logic [2:0] PRED1 = 3'((n % 4) * 2 + 1);
      localparam logic       BIT   = 1'(n / 4);

      logic [1:0]              diff0, diff1;
      logic [METRIC_WIDTH-1:0] cand0, cand1;

      assign diff0 = rx_pair ^ expected_pair(PRED0, BIT);
      assign diff1 = rx_pair ^ expected_pair(PRED1, BIT);

      assign cand0 = metric_in[PRED0]
                   + {{(METRIC_WIDTH-2){1'b0}}, diff0[1] & diff0[0], diff0[1] ^ diff0[0]};
      assign cand1 = metric_in[PRED1]
                   + {{(METRIC_WIDTH-2){1'b0}}, diff1[1] & diff1[0], diff1[1] ^ diff1[0]};

      // Strict compare so ties resolve to the s0=0 predecessor.
      assign decision[n]   = (cand1 < cand0);
      assign metric_out[n] = (cand1 < cand0) ? cand1 : cand0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/fec_viterbi_decoder.sv
`default_nettype none
// ------------------------------------------------------------------------
// fec_viterbi_decoder : sequential hard-decision Viterbi decoder with traceback (rev 1.0)
// ------------------------------------------------------------------------
module fec_viterbi_decoder
  import fec_pkg::*;
#(
  parameter int DATA_WIDTH   = 48,
  parameter int METRIC_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [2*DATA_WIDTH-1:0] fec_in,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic [METRIC_WIDTH-1:0] metric_out
);

  localparam int                CNT_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(DATA_WIDTH - 1);
  localparam logic [METRIC_WIDTH-1:0] METRIC_INIT = {1'b1, {(METRIC_WIDTH-1){1'b0}}};

  vit_state_t state, state_nxt;

  logic [2*DATA_WIDTH-1:0]                frame;
  logic [NUM_STATES-1:0][METRIC_WIDTH-1:0] metrics;
  logic [NUM_STATES-1:0][METRIC_WIDTH-1:0] acs_metrics;
  logic [NUM_STATES-1:0]                  acs_dec;
  logic [NUM_STATES-1:0]                  survivor [DATA_WIDTH];
  logic [CNT_W-1:0]                       step;
  logic [2:0]                             best_state;
  logic [METRIC_WIDTH-1:0]                best_metric;
  logic [METRIC_WIDTH-1:0]                sel_metric;
  logic [2:0]                             trace_state;
  logic [DATA_WIDTH-1:0]                  data_sr;

  viterbi_acs #(
    .METRIC_WIDTH (METRIC_WIDTH)
  ) u_acs (
    .metric_in  (metrics),
    .rx_pair    (frame[2*DATA_WIDTH-1:2*DATA_WIDTH-2]),
    .metric_out (acs_metrics),
    .decision   (acs_dec)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_ACS;
      ST_ACS:    if (step == LAST_STEP) state_nxt = ST_SELECT;
      ST_SELECT: state_nxt = ST_TRACE;
      ST_TRACE:  if (step == '0) state_nxt = ST_FINISH;
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Lowest-index state wins among equal minimum metrics.
  always_comb begin
    best_state  = 3'd0;
    best_metric = metrics[0];
    for (int i = 1; i < NUM_STATES; i++) begin
      if (metrics[i] < best_metric) begin
        best_metric = metrics[i];
        best_state  = 3'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      data_out    <= '0;
      metric_out  <= '0;
      frame       <= '0;
      metrics     <= '0;
      step        <= '0;
      sel_metric  <= '0;
      trace_state <= '0;
      data_sr     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            frame <= fec_in;
            for (int i = 0; i < NUM_STATES; i++)
              metrics[i] <= (i == 0) ? '0 : METRIC_INIT;
            step <= '0;
            busy <= 1'b1;
          end
        end
        ST_ACS: begin
          metrics <= acs_metrics;
          frame   <= {frame[2*DATA_WIDTH-3:0], 2'b00};
          step    <= step + 1'b1;
        end
        ST_SELECT: begin
          sel_metric  <= best_metric;
          trace_state <= best_state;
          step        <= LAST_STEP;
        end
        ST_TRACE: begin
          // Bits emerge last-first; shifting in at the top lands the first-encoded bit at the MSB.
          data_sr     <= {trace_state[2], data_sr[DATA_WIDTH-1:1]};
          trace_state <= {trace_state[1:0], survivor[step][trace_state]};
          step        <= step - 1'b1;
        end
        ST_FINISH: begin
          data_out   <= data_sr;
          metric_out <= sel_metric;
          done       <= 1'b1;
          busy       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_ACS) survivor[step] <= acs_dec;
  end

endmodule
`default_nettype wire

// File: tb/tb_fec_viterbi_decoder.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_fec_viterbi_decoder : scoreboard bench for fec_viterbi_decoder (rev 1.0)
// ------------------------------------------------------------------------
module tb_fec_viterbi_decoder;

  localparam int W  = 48;
  localparam int MW = 8;
  localparam int LATENCY = 2 * W + 2;

  logic            clk;
  logic            reset_n;
  logic            start;
  logic [2*W-1:0]  fec_in;
  logic            busy;
  logic            done;
  logic [W-1:0]    data_out;
  logic [MW-1:0]   metric_out;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [MW-1:0] metric;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  fec_viterbi_decoder #(.DATA_WIDTH(W), .METRIC_WIDTH(MW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .fec_in     (fec_in),
    .busy       (busy),
    .done       (done),
    .data_out   (data_out),
    .metric_out (metric_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] encode(input logic [W-1:0] payload);
    logic [2:0]     s;
    logic           b;
    logic [2*W-1:0] f;
    s = 3'd0;
    f = '0;
    for (int i = 0; i < W; i++) begin
      b = payload[W-1-i];
      f[2*W-1-2*i] = b ^ s[2] ^ s[1] ^ s[0];
      f[2*W-2-2*i] = b ^ s[1] ^ s[0];
      s = {b, s[2:1]};
    end
    return f;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
      end else begin
        e = sb.pop_front();
        check("data_out",     64'(data_out),   64'(e.data));
        check("metric_out",   64'(metric_out), 64'(e.metric));
        check("done_cycle",   64'(cyc),        64'(e.cyc));
        check("busy_at_done", 64'(busy),       64'd0);
      end
    end
  end

  // Issues a frame at the next negedge and returns the cycle stamp of its accept edge.
  task automatic issue(input logic [2*W-1:0] frame, output int c0);
    @(negedge clk);
    fec_in = frame;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    c0    = cyc;
    check("busy_after_accept", 64'(busy), 64'd1);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 400) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic run_frame(input logic [W-1:0] payload, input logic [2*W-1:0] flips,
                           input logic [MW-1:0] exp_metric);
    int   c0;
    exp_t e;
    issue(encode(payload) ^ flips, c0);
    e.data   = payload;
    e.metric = exp_metric;
    e.cyc    = c0 + LATENCY;
    sb.push_back(e);
    drain();
  endtask

  initial begin
    logic [2*W-1:0] flips;
    logic [2*W-1:0] fa, fb;
    logic [W-1:0]   pa, pb;
    int             c0, guard;
    bit             saw_done;
    exp_t           e;

    reset_n = 1'b0;
    start   = 1'b0;
    fec_in  = '0;
    repeat (3) @(negedge clk);
    check("reset_busy",       64'(busy),       64'd0);
    check("reset_done",       64'(done),       64'd0);
    check("reset_data_out",   64'(data_out),   64'd0);
    check("reset_metric_out", 64'(metric_out), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(48'h0, '0, 8'd0);
    run_frame(48'hA5A5_1234_5678, '0, 8'd0);
    flips = '0;
    flips[95] = 1'b1;
    run_frame(48'hA5A5_1234_5678, flips, 8'd1);
    flips = '0;
    flips[10] = 1'b1;
    flips[80] = 1'b1;
    run_frame(48'hFFFF_FFFF_FFFF, flips, 8'd2);

    // Abandon a frame mid-ACS; no expectation is queued so any done is flagged.
    issue(encode(48'h1357_9BDF_2468), c0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset_busy",       64'(busy),       64'd0);
    check("midreset_done",       64'(done),       64'd0);
    check("midreset_data_out",   64'(data_out),   64'd0);
    check("midreset_metric_out", 64'(metric_out), 64'd0);
    @(negedge clk);
    reset_n  = 1'b1;
    saw_done = 1'b0;
    repeat (110) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("midreset_no_done", 64'(saw_done), 64'd0);
    run_frame(48'h0F1E_2D3C_4B5A, '0, 8'd0);

    // Busy-time start ignored, then start held across done for back-to-back frames.
    pa = 48'hDEAD_BEEF_CAFE;
    pb = 48'h0123_4567_89AB;
    fa = encode(pa);
    fb = encode(pb);
    issue(fa, c0);
    e.data = pa; e.metric = 8'd0; e.cyc = c0 + LATENCY;
    sb.push_back(e);
    e.data = pb; e.metric = 8'd0; e.cyc = c0 + LATENCY + 1 + LATENCY;
    sb.push_back(e);
    fec_in = ~fa;
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (70) @(negedge clk);
    fec_in = fb;
    start  = 1'b1;
    guard  = 0;
    while (cyc < c0 + LATENCY + 1 && guard < 300) begin
      @(posedge clk);
      #1;
      guard++;
    end
    start = 1'b0;
    check("b_accept_cycle", 64'(cyc),  64'(c0 + LATENCY + 1));
    check("b_busy",         64'(busy), 64'd1);
    fec_in = '0;
    drain();

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
